// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single vga_adapter write port; the granted engine's pixel stream is registered out.
// Optional grant watchdog: define VGA_ARB_TIMEOUT_EN.
module vga_draw_arbiter #(
  parameter int          NUM_REQ  = 3,
  parameter logic [15:0] MAX_HOLD = 16'd40000
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     done,
  input  logic [9*NUM_REQ-1:0]   x_in,
  input  logic [9*NUM_REQ-1:0]   y_in,
  input  logic [6*NUM_REQ-1:0]   colour_in,
  input  logic [NUM_REQ-1:0]     plot_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [8:0]             x,
  output logic [8:0]             y,
  output logic [5:0]             colour,
  output logic                   writeEn,
  output logic                   busy,
  output logic                   timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_win;

  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic            w_plot;
  logic            w_done;
  logic            w_req;
  logic            w_expire;
  logic [8:0]      w_x;
  logic [8:0]      w_y;
  logic [5:0]      w_col;

  // Scan from the farthest offset down so the nearest requester after r_ptr wins.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[IW'((int'(r_ptr) + off) % NUM_REQ)]) begin
        w_pick = IW'((int'(r_ptr) + off) % NUM_REQ);
        w_any  = 1'b1;
      end
    end
  end

  assign w_plot = plot_in[r_win];
  assign w_done = done[r_win];
  assign w_req  = req[r_win];
  assign w_x    = x_in[9*int'(r_win) +: 9];
  assign w_y    = y_in[9*int'(r_win) +: 9];
  assign w_col  = colour_in[6*int'(r_win) +: 6];

`ifdef VGA_ARB_TIMEOUT_EN
  logic [15:0] r_hold;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= '0;
    end else if (r_state == S_GRANT) begin
      r_hold <= r_hold + 16'd1;
    end else begin
      r_hold <= '0;
    end
  end

  assign w_expire = (r_state == S_GRANT) && (r_hold == MAX_HOLD - 16'd1);
`else
  logic w_unused;
  assign w_unused = ^MAX_HOLD;
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_win   <= '0;
      grant   <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          writeEn <= 1'b0;
          if (w_any) begin
            r_win   <= w_pick;
            grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
            busy    <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Coordinates only move with a real pixel so they hold while writeEn is low.
          writeEn <= w_plot;
          if (w_plot) begin
            x      <= w_x;
            y      <= w_y;
            colour <= w_col;
          end
          if (w_done || !w_req || w_expire) begin
            grant   <= '0;
            timeout <= w_expire && !w_done && w_req;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          writeEn <= 1'b0;
          r_ptr   <= r_win;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          grant   <= '0;
          writeEn <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter: latency, rotation, isolation, async reset and the watchdog.
module tb_vga_draw_arbiter;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     done = '0;
  logic [9*N-1:0]   x_in = '0;
  logic [9*N-1:0]   y_in = '0;
  logic [6*N-1:0]   colour_in = '0;
  logic [N-1:0]     plot_in = '0;
  logic [N-1:0]     grant;
  logic [8:0]       x;
  logic [8:0]       y;
  logic [5:0]       colour;
  logic             writeEn;
  logic             busy;
  logic             timeout;

  int n_chk = 0;
  int n_bad = 0;

  vga_draw_arbiter #(.NUM_REQ(N), .MAX_HOLD(16'd16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
    .grant(grant), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int e, input int px, input int py, input int pc);
    x_in[9*e +: 9]      = 9'(px);
    y_in[9*e +: 9]      = 9'(py);
    colour_in[6*e +: 6] = 6'(pc);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
  endtask

  logic [N-1:0] exp_order [4];
  int low;
  int c;
  logic to_seen;

  initial begin
    exp_order[0] = 3'b001;
    exp_order[1] = 3'b010;
    exp_order[2] = 3'b100;
    exp_order[3] = 3'b001;

    // reset state
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_we", 32'(writeEn), 0);
    chk("rst_x", 32'(x), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_to", 32'(timeout), 0);
    resetn = 1'b1;
    tick();

    // single engine, three pixels, done with last pixel
    req = 3'b001;
    chk("t1_pre_grant", 32'(grant), 0);
    tick();
    chk("t1_grant", 32'(grant), 32'b001);
    chk("t1_busy", 32'(busy), 1);
    set_pix(0, 10, 44, 6'b001001);
    plot_in = 3'b001;
    tick();
    chk("t1_we0", 32'(writeEn), 1);
    chk("t1_x0", 32'(x), 10);
    chk("t1_y0", 32'(y), 44);
    chk("t1_c0", 32'(colour), 32'b001001);
    set_pix(0, 11, 44, 6'b001001);
    tick();
    chk("t1_x1", 32'(x), 11);
    set_pix(0, 12, 44, 6'b001001);
    done = 3'b001;
    tick();
    chk("t1_we2", 32'(writeEn), 1);
    chk("t1_x2", 32'(x), 12);
    chk("t1_grant_rel", 32'(grant), 0);
    chk("t1_busy_rel", 32'(busy), 1);
    done = '0;
    plot_in = '0;
    req = '0;
    tick();
    chk("t1_we_off", 32'(writeEn), 0);
    chk("t1_x_hold", 32'(x), 12);
    chk("t1_busy_idle", 32'(busy), 0);

    // rotation with all three requesting
    pulse_reset();
    req = 3'b111;
    low = 0;
    while (grant == '0 && low < 10) begin
      tick();
      low++;
    end
    chk("t2_first_lat", 32'(low), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_order%0d", i), 32'(grant), 32'(exp_order[i]));
      repeat (4) tick();
      chk($sformatf("t2_hold%0d", i), 32'(grant), 32'(exp_order[i]));
      done = grant;
      tick();
      done = '0;
      if (i == 3) req = '0;
      low = 0;
      while (grant == '0 && low < 10) begin
        low++;
        tick();
      end
      if (i < 3) chk($sformatf("t2_gap%0d", i), 32'(low), 2);
    end
    repeat (3) tick();

    // engine 1 owns the port while engine 2 plots at (300,200)
    set_pix(2, 300, 200, 6'b111111);
    plot_in = 3'b100;
    req = 3'b010;
    tick();
    chk("t3_grant", 32'(grant), 32'b010);
    chk("t3_we_none", 32'(writeEn), 0);
    set_pix(1, 5, 6, 6'b000011);
    plot_in = 3'b110;
    tick();
    chk("t3_we1", 32'(writeEn), 1);
    chk("t3_x1", 32'(x), 5);
    chk("t3_y1", 32'(y), 6);
    set_pix(1, 7, 6, 6'b000011);
    plot_in = 3'b100;
    tick();
    chk("t3_we_gap", 32'(writeEn), 0);
    chk("t3_x_hold", 32'(x), 5);
    set_pix(1, 8, 9, 6'b000011);
    plot_in = 3'b110;
    tick();
    chk("t3_x2", 32'(x), 8);
    chk("t3_y2", 32'(y), 9);
    done = 3'b010;
    plot_in = 3'b100;
    tick();
    done = '0;
    req = '0;
    chk("t3_grant_rel", 32'(grant), 0);
    chk("t3_we_rel", 32'(writeEn), 0);
    plot_in = '0;
    repeat (3) tick();

    // async reset mid-draw
    req = 3'b001;
    set_pix(0, 100, 50, 6'b111111);
    plot_in = 3'b001;
    tick();
    chk("t4_grant", 32'(grant), 32'b001);
    tick();
    chk("t4_we", 32'(writeEn), 1);
    chk("t4_x", 32'(x), 100);
    resetn = 1'b0;
    #1;
    chk("t4_rst_grant", 32'(grant), 0);
    chk("t4_rst_we", 32'(writeEn), 0);
    chk("t4_rst_x", 32'(x), 0);
    chk("t4_rst_y", 32'(y), 0);
    chk("t4_rst_col", 32'(colour), 0);
    chk("t4_rst_busy", 32'(busy), 0);
    plot_in = '0;
    req = 3'b111;
    tick();
    resetn = 1'b1;
    tick();
    chk("t4_first_after_rst", 32'(grant), 32'b001);
    done = 3'b001;
    req = '0;
    tick();
    done = '0;
    repeat (3) tick();

    // watchdog: engine 0 never finishes, engine 1 waiting
    pulse_reset();
    req = 3'b011;
    tick();
    chk("t5_grant0", 32'(grant), 32'b001);
    c = 0;
    to_seen = 1'b0;
`ifdef VGA_ARB_TIMEOUT_EN
    while (grant == 3'b001 && c < 2000) begin
      to_seen = to_seen | timeout;
      c++;
      tick();
    end
    chk("t5_hold_cycles", 32'(c), 16);
    chk("t5_to_early", 32'(to_seen), 0);
    chk("t5_to_pulse", 32'(timeout), 1);
    chk("t5_grant_rel", 32'(grant), 0);
    tick();
    chk("t5_to_clear", 32'(timeout), 0);
    tick();
    chk("t5_grant1", 32'(grant), 32'b010);
    done = 3'b010;
    req = '0;
    tick();
    done = '0;
`else
    while (grant == 3'b001 && c < 1000) begin
      to_seen = to_seen | timeout;
      c++;
      tick();
    end
    chk("t5_hold_cycles", 32'(c), 1000);
    chk("t5_still_grant", 32'(grant), 32'b001);
    chk("t5_no_to", 32'(to_seen | timeout), 0);
    done = 3'b001;
    req = '0;
    tick();
    done = '0;
    chk("t5_grant_rel", 32'(grant), 0);
`endif
    repeat (3) tick();
    chk("end_idle_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
